// File: rtl/logic_unit_pipe.sv
`timescale 1ns/1ps
// logic_unit_pipe: registered bitwise logic unit (8 run-time ops) with one valid/ready output stage,
// result flags and a completed-transaction counter. Define LOGIC_UNIT_ACC_EN to add accumulator feedback on B.
module logic_unit_pipe #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
`ifdef LOGIC_UNIT_ACC_EN
   input  logic             acc_sel,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic             y_ones,
   output logic             y_par,
   output logic [CNT_W-1:0] txn_cnt
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_NAND = 3'b010,
      OP_NOR  = 3'b011,
      OP_XOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_NOTA = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;
   logic             par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] res;
   logic             accept;
   logic             drain;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = valid_q && out_ready;

`ifdef LOGIC_UNIT_ACC_EN
   logic [WIDTH-1:0] acc_q;

   assign b_eff = acc_sel ? acc_q : b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      acc_q <= '0;
      else if (accept) acc_q <= res;
   end
`else
   assign b_eff = b;
`endif

   always_comb begin
      case (op_e'(op))
         OP_AND:  res = a & b_eff;
         OP_OR:   res = a | b_eff;
         OP_NAND: res = ~(a & b_eff);
         OP_NOR:  res = ~(a | b_eff);
         OP_XOR:  res = a ^ b_eff;
         OP_XNOR: res = ~(a ^ b_eff);
         OP_NOTA: res = ~a;
         default: res = a;
      endcase
   end

   // NOTE: every signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      y_d     = y_q;
      zero_d  = zero_q;
      ones_d  = ones_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      if (drain) begin
         cnt_d   = cnt_q + CNT_W'(1);
         valid_d = 1'b0;
      end
      if (accept) begin
         valid_d = 1'b1;
         y_d     = res;
         zero_d  = (res == '0);
         ones_d  = &res;
         par_d   = ^res;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         y_q     <= '0;
         zero_q  <= 1'b1;
         ones_q  <= 1'b0;
         par_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
         ones_q  <= ones_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign y         = y_q;
   assign y_zero    = zero_q;
   assign y_ones    = ones_q;
   assign y_par     = par_q;
   assign txn_cnt   = cnt_q;

endmodule
